// File: rtl/regfile_scoreboard_if.sv
// Decode, write-back and execute-side signals of the banked register file.
// The slave modport is the register file; the master modport is its environment.
interface regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int NBANK = 2,
  parameter int NREG  = 32
);
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  logic            in_valid;
  logic            in_ready;
  logic [BW-1:0]   rs_bank;
  logic [IW-1:0]   rs_idx;
  logic            rs_use;
  logic [BW-1:0]   rt_bank;
  logic [IW-1:0]   rt_idx;
  logic            rt_use;
  logic [BW-1:0]   rd_bank;
  logic [IW-1:0]   rd_idx;
  logic            rd_we;
  logic            wb_we;
  logic [BW-1:0]   wb_bank;
  logic [IW-1:0]   wb_idx;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_s;
  logic [XLEN-1:0] out_t;
  logic [BW-1:0]   out_rd_bank;
  logic [IW-1:0]   out_rd_idx;
  logic            out_rd_we;
  logic            busy;

  modport master (
    output in_valid, rs_bank, rs_idx, rs_use, rt_bank, rt_idx, rt_use,
           rd_bank, rd_idx, rd_we, wb_we, wb_bank, wb_idx, wb_data, out_ready,
    input  in_ready, out_valid, out_s, out_t, out_rd_bank, out_rd_idx,
           out_rd_we, busy
  );

  modport slave (
    input  in_valid, rs_bank, rs_idx, rs_use, rt_bank, rt_idx, rt_use,
           rd_bank, rd_idx, rd_we, wb_we, wb_bank, wb_idx, wb_data, out_ready,
    output in_ready, out_valid, out_s, out_t, out_rd_bank, out_rd_idx,
           out_rd_we, busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Banked register file with pending-write scoreboard, write-back forwarding
// and a registered operand-issue stage between decode and execute.
module regfile_scoreboard #(
  parameter int XLEN    = 32,
  parameter int NBANK   = 2,
  parameter int NREG    = 32,
  parameter int ZERO_R0 = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  regfile_scoreboard_if.slave  rf
);
  localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1;
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [XLEN-1:0]            mem_q [NBANK][NREG];
  logic [NBANK-1:0][NREG-1:0] pend_q, pend_d;

  logic            out_valid_q;
  logic [XLEN-1:0] out_s_q, out_t_q;
  logic [BW-1:0]   out_rd_bank_q;
  logic [IW-1:0]   out_rd_idx_q;
  logic            out_rd_we_q;

  logic            zero_s, zero_t, zero_d, zero_wb;
  logic            wb_hit_s, wb_hit_t, wb_hit_d;
  logic            haz_s, haz_t, haz_d;
  logic [XLEN-1:0] src_s, src_t;
  logic            accept;

  function automatic logic is_zero(input logic [BW-1:0] b, input logic [IW-1:0] i);
    return (ZERO_R0 != 0) && (b == '0) && (i == '0);
  endfunction

  always_comb begin
    zero_s   = is_zero(rf.rs_bank, rf.rs_idx);
    zero_t   = is_zero(rf.rt_bank, rf.rt_idx);
    zero_d   = is_zero(rf.rd_bank, rf.rd_idx);
    zero_wb  = is_zero(rf.wb_bank, rf.wb_idx);
    wb_hit_s = rf.wb_we && (rf.wb_bank == rf.rs_bank) && (rf.wb_idx == rf.rs_idx);
    wb_hit_t = rf.wb_we && (rf.wb_bank == rf.rt_bank) && (rf.wb_idx == rf.rt_idx);
    wb_hit_d = rf.wb_we && (rf.wb_bank == rf.rd_bank) && (rf.wb_idx == rf.rd_idx);

    // A write-back landing this cycle resolves the hazard it would otherwise raise.
    haz_s = rf.rs_use && !zero_s && pend_q[rf.rs_bank][rf.rs_idx] && !wb_hit_s;
    haz_t = rf.rt_use && !zero_t && pend_q[rf.rt_bank][rf.rt_idx] && !wb_hit_t;
    haz_d = rf.rd_we  && !zero_d && pend_q[rf.rd_bank][rf.rd_idx] && !wb_hit_d;

    if (zero_s)        src_s = '0;
    else if (wb_hit_s) src_s = rf.wb_data;
    else               src_s = mem_q[rf.rs_bank][rf.rs_idx];

    if (zero_t)        src_t = '0;
    else if (wb_hit_t) src_t = rf.wb_data;
    else               src_t = mem_q[rf.rt_bank][rf.rt_idx];

    rf.in_ready = !(haz_s || haz_t || haz_d) && (!out_valid_q || rf.out_ready);
    accept      = rf.in_valid && rf.in_ready;
  end

  // Clear before set so a same-cycle issue to the written register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (rf.wb_we)
      pend_d[rf.wb_bank][rf.wb_idx] = 1'b0;
    if (accept && rf.rd_we && !zero_d)
      pend_d[rf.rd_bank][rf.rd_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rf.wb_we && !zero_wb)
      mem_q[rf.wb_bank][rf.wb_idx] <= rf.wb_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q        <= '0;
      out_valid_q   <= 1'b0;
      out_s_q       <= '0;
      out_t_q       <= '0;
      out_rd_bank_q <= '0;
      out_rd_idx_q  <= '0;
      out_rd_we_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (accept) begin
        out_valid_q   <= 1'b1;
        out_s_q       <= src_s;
        out_t_q       <= src_t;
        out_rd_bank_q <= rf.rd_bank;
        out_rd_idx_q  <= rf.rd_idx;
        out_rd_we_q   <= rf.rd_we;
      end else if (rf.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign rf.out_valid   = out_valid_q;
  assign rf.out_s       = out_s_q;
  assign rf.out_t       = out_t_q;
  assign rf.out_rd_bank = out_rd_bank_q;
  assign rf.out_rd_idx  = out_rd_idx_q;
  assign rf.out_rd_we   = out_rd_we_q;
  assign rf.busy        = |pend_q;
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-bank register file with pending-write scoreboard, write-back forwarding and a registered operand-issue stage. It sits between instruction decode and execute. It replaces fixed integer/float register arrays with NBANK banks of NREG registers, and stalls issue on RAW/WAW hazards against in-flight multi-cycle results instead of relying on software-visible wait counts.

## Interface
Parameters:
- XLEN, 32: register data width
- NBANK, 2: number of register banks (bank 0 = integer, bank 1 = float by convention)
- NREG, 32: registers per bank
- ZERO_R0, 1: when 1, bank 0 register 0 reads 0, ignores writes, never becomes pending
- BW, $clog2(NBANK) min 1: bank select width (derived)
- IW, $clog2(NREG): register index width (derived)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- rs_bank / rs_idx  in  BW / IW  source 1 register
- rs_use  in  1  source 1 is read (hazard checked only if set)
- rt_bank / rt_idx  in  BW / IW  source 2 register
- rt_use  in  1  source 2 is read
- rd_bank / rd_idx  in  BW / IW  destination register
- rd_we  in  1  instruction writes rd
- wb_we  in  1  write-back strobe
- wb_bank / wb_idx  in  BW / IW  write-back destination
- wb_data  in  XLEN  write-back value
- out_valid  out  1  operand bundle valid to execute
- out_ready  in  1  execute accepts bundle
- out_s / out_t  out  XLEN  source operands
- out_rd_bank / out_rd_idx  out  BW / IW  destination passed through
- out_rd_we  out  1  write flag passed through
- busy  out  1  OR of all pending bits

## Operation
- Storage: NBANK×NREG×XLEN array, not reset; initialised to all zeros at configuration. Write on rising clk when wb_we, except the ZERO_R0 register.
- Pending bits: NBANK×NREG, reset to 0. Set on accept when rd_we, cleared when wb_we targets that register. If both occur on the same register in the same cycle, set wins.
- Read path: combinational array read of rs and rt. If wb_we matches the source bank/idx in the same cycle, wb_data is forwarded. The ZERO_R0 register always reads 0.
- Hazard:
  - RAW: rs_use/rt_use and the source is pending, unless wb_we clears it this cycle.
  - WAW: rd_we and rd is pending, unless wb_we clears it this cycle.
  - The ZERO_R0 register is never hazardous.
- in_ready = !hazard && (!out_valid || out_ready). in_ready is combinational and does not depend on in_valid.
- On accept: out_s, out_t and the rd fields load and out_valid <= 1.
- When out_valid && out_ready and there is no accept: out_valid <= 0.
- Output fields are held stable while out_valid && !out_ready.
- A write-back to a register already captured in the output stage does not update out_s/out_t. This is safe because a captured source is never pending.
- A write-back to a non-pending register is legal: the array is updated and pending bits are unchanged.
- Same-bank and cross-bank indices are independent: bank 1 reg 0 is an ordinary register.

## Timing
- Reset (rstn low, asynchronous):
  - out_valid=0, out_s=0, out_t=0, out_rd_bank=0, out_rd_idx=0, out_rd_we=0.
  - All pending bits 0, so busy=0.
- Reset mid-operation discards the output bundle and all pending state. Array contents are retained.
- Issue latency: 1 cycle from accept to out_valid.
- Throughput: 1 bundle/cycle when there are no hazards and out_ready is held high.
- Write-back to dependent issue:
  - The dependent instruction is accepted in the same cycle as wb_we, via forwarding.
  - Minimum RAW bubble is therefore the producer's latency only.
- busy reflects pending bits registered at the previous edge.

## Test plan
- Reset, then issue rs=(0,5), rt=(1,3), rd=(0,7), rd_we=1, out_ready=1 -> next cycle out_valid=1, out_s=0, out_t=0, busy=1, pending(0,7)=1.
- With (0,7) pending, present rs=(0,7) -> in_ready=0 for 4 cycles. On cycle 5 assert wb_we (0,7)=0xDEADBEEF -> in_ready=1 that cycle, next cycle out_s=0xDEADBEEF, pending(0,7)=0.
- Issue rd=(1,2) rd_we=1 back-to-back with a second rd=(1,2) rd_we=1 -> second stalls (WAW) until wb to (1,2). Same-cycle wb+accept leaves pending(1,2)=1.
- Hold out_ready=0 with out_valid=1 for 3 cycles -> in_ready=0, outputs stable. Release -> next bundle loads on the following edge with no loss or duplication.
- ZERO_R0: wb_we (0,0)=0x12345678, then issue rs=(0,0), rd=(0,0) rd_we=1 -> out_s=0, no stall, busy unchanged. Same test on (1,0) -> value 0x12345678 read back, pending set.
- Deassert rstn asynchronously while out_valid=1 and 3 registers are pending -> out_valid=0 and busy=0 immediately. After release, a previously written value is read back unchanged.
